bus_fabric: RTL

Parametrised single-master bus interconnect. It sits between the CPU and its memories and peripherals, and replaces the fixed address-decode and read-mux logic in the SoC top. It decodes each access into one of `NUM_SLAVES` windows and runs a valid/ready handshake with per-slave wait states. It registers read data and reports unmapped or stalled accesses through a sticky error log, so the bus no longer halts simulation.

---
 rtl/bus_fabric.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// bus_fabric: single-master decoder with valid/ready handshake, registered read mux and a sticky error log.
// Optional macro BUS_TIMEOUT_EN aborts an ACCESS that sees no sReady within TIMEOUT cycles.
module bus_fabric #(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'hF0000000, 32'h05E00000, 32'h00010000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000},
  parameter int                       TIMEOUT    = 16,
  parameter logic [31:0]              ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mValid,
  input  logic                       mWrite,
  input  logic [31:0]                mAddress,
  input  logic [31:0]                mDataIn,
  output logic                       mReady,
  output logic [31:0]                mDataOut,
  output logic                       mError,
  output logic [NUM_SLAVES-1:0]      sChipSelect,
  output logic                       sWriteEnable,
  output logic [31:0]                sAddress,
  output logic [31:0]                sDataIn,
  input  logic [NUM_SLAVES*32-1:0]   sDataOut,
  input  logic [NUM_SLAVES-1:0]      sReady,
  input  logic                       errClear,
  output logic                       errValid,
  output logic [31:0]                errAddress,
  output logic                       errWrite,
  output logic                       errTimeout,
  output logic [7:0]                 errCount
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic                  r_write;
  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_hit;
  logic [IW-1:0]         w_idx;
  logic                  w_sready;
  logic [31:0]           w_sdata;
  logic                  w_err_done;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("bus_fabric: parameter out of range");
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt;
  logic       r_timeout;
`endif

  // Window compare; the descending scan leaves the lowest matching index in w_idx.
  always_comb begin
    w_match = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_match[i] = ((mAddress ^ SLAVE_BASE[32*i +: 32]) & SLAVE_MASK[32*i +: 32]) == 32'h0;
    end
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      w_idx = w_match[i] ? IW'(i) : w_idx;
    end
  end

  assign w_hit      = |w_match;
  assign w_onehot   = NUM_SLAVES'(1'b1) << w_idx;
  assign w_sready   = sReady[r_idx];
  assign w_sdata    = sDataOut[32*r_idx +: 32];
  assign w_err_done = (r_state == S_RESP) && mError;

  // Transaction FSM; every bus-facing output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_write      <= 1'b0;
      mReady       <= 1'b0;
      mDataOut     <= 32'h0;
      mError       <= 1'b0;
      sChipSelect  <= '0;
      sWriteEnable <= 1'b0;
      sAddress     <= 32'h0;
      sDataIn      <= 32'h0;
`ifdef BUS_TIMEOUT_EN
      r_cnt        <= 8'd0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mValid) begin
            sAddress <= mAddress;
            sDataIn  <= mDataIn;
            r_write  <= mWrite;
            r_idx    <= w_idx;
`ifdef BUS_TIMEOUT_EN
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
`endif
            if (w_hit) begin
              r_state      <= S_ACCESS;
              sChipSelect  <= w_onehot;
              sWriteEnable <= mWrite;
            end else begin
              r_state  <= S_RESP;
              mReady   <= 1'b1;
              mError   <= 1'b1;
              mDataOut <= ERR_DATA;
            end
          end
        end
        S_ACCESS: begin
          if (w_sready) begin
            r_state      <= S_RESP;
            sChipSelect  <= '0;
            sWriteEnable <= 1'b0;
            mReady       <= 1'b1;
            mError       <= 1'b0;
            if (!r_write) begin
              mDataOut <= w_sdata;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            r_state      <= S_RESP;
            sChipSelect  <= '0;
            sWriteEnable <= 1'b0;
            mReady       <= 1'b1;
            mError       <= 1'b1;
            mDataOut     <= ERR_DATA;
            r_timeout    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
          mReady  <= 1'b0;
          mError  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky log; a clear coinciding with an error completion still records that error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errValid   <= 1'b0;
      errCount   <= 8'd0;
      errAddress <= 32'h0;
      errWrite   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      errTimeout <= 1'b0;
`endif
    end else if (w_err_done) begin
      errValid <= 1'b1;
      if (errClear) begin
        errCount <= 8'd1;
      end else if (errCount != 8'hFF) begin
        errCount <= errCount + 8'd1;
      end
      if (!errValid || errClear) begin
        errAddress <= sAddress;
        errWrite   <= r_write;
`ifdef BUS_TIMEOUT_EN
        errTimeout <= r_timeout;
`endif
      end
    end else if (errClear) begin
      errValid <= 1'b0;
      errCount <= 8'd0;
    end
  end

`ifndef BUS_TIMEOUT_EN
  assign errTimeout = 1'b0;
`endif

endmodule
